// File: rtl/bg_scroll_mapper.sv
// Background pixel mapper: raster position -> scaled, scrolled ROM address -> palette index -> VGA colour.
// Fixed four-cycle latency from DrawX/DrawY/blank to VGA_R/G/B and pix_valid.
module bg_scroll_mapper #(
  parameter int IMG_W        = 320,
  parameter int IMG_H        = 240,
  parameter int SCALE_SHIFT  = 1,
  parameter int PIX_BITS     = 8,
  parameter int PIX_PER_WORD = 8,
  localparam int WORD_W = PIX_BITS * PIX_PER_WORD,
  localparam int WPR    = IMG_W / PIX_PER_WORD,
  localparam int ADDR_W = $clog2(WPR * IMG_H),
  localparam int SXW    = $clog2(IMG_W),
  localparam int SYW    = $clog2(IMG_H)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic                blank,
  input  logic                frame_start,
  input  logic                scroll_we,
  input  logic [SXW-1:0]      scroll_x,
  input  logic [SYW-1:0]      scroll_y,
  output logic                scroll_err,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [WORD_W-1:0]   rom_q,
  output logic [PIX_BITS-1:0] pal_idx,
  input  logic [23:0]         pal_rgb,
  output logic [3:0]          VGA_R,
  output logic [3:0]          VGA_G,
  output logic [3:0]          VGA_B,
  output logic                pix_valid
);

  localparam int LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [SXW:0]    IMG_W_L = (SXW+1)'(IMG_W);
  localparam logic [SYW:0]    IMG_H_L = (SYW+1)'(IMG_H);
  localparam logic [SXW:0]    PPW_L   = (SXW+1)'(PIX_PER_WORD);
  localparam logic [ADDR_W-1:0] WPR_L = ADDR_W'(WPR);

  // Operands are both below the image size, so one conditional subtract wraps the sum.
  function automatic logic [SXW-1:0] wrap_x(input logic [SXW-1:0] a, input logic [SXW-1:0] b);
    logic [SXW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= IMG_W_L) s = s - IMG_W_L;
    return s[SXW-1:0];
  endfunction

  function automatic logic [SYW-1:0] wrap_y(input logic [SYW-1:0] a, input logic [SYW-1:0] b);
    logic [SYW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= IMG_H_L) s = s - IMG_H_L;
    return s[SYW-1:0];
  endfunction

  // Lane 0 is the leftmost pixel and sits in the MSBs of the word.
  function automatic logic [PIX_BITS-1:0] lane_sel(input logic [WORD_W-1:0] w,
                                                   input logic [LANE_W-1:0] l);
    logic [PIX_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < PIX_PER_WORD; i++)
      if (l == LANE_W'(i)) r = w[WORD_W-1-i*PIX_BITS -: PIX_BITS];
    return r;
  endfunction

  logic [SXW-1:0]    sh_x, ac_x;
  logic [SYW-1:0]    sh_y, ac_y;
  logic              wr_ok;
  logic [9:0]        hx, hy;
  logic              in_img;
  logic [SXW-1:0]    sx;
  logic [SYW-1:0]    sy;
  logic [ADDR_W-1:0] addr_nxt;
  logic [LANE_W-1:0] lane_nxt;
  logic [LANE_W-1:0] lane_p0, lane_p1;
  logic              vld_p0, vld_p1, vld_p2, vld_p3;

  assign wr_ok    = ({1'b0, scroll_x} < IMG_W_L) && ({1'b0, scroll_y} < IMG_H_L);
  assign hx       = DrawX >> SCALE_SHIFT;
  assign hy       = DrawY >> SCALE_SHIFT;
  assign in_img   = (hx < 10'(IMG_W)) && (hy < 10'(IMG_H));
  assign sx       = wrap_x(hx[SXW-1:0], ac_x);
  assign sy       = wrap_y(hy[SYW-1:0], ac_y);
  assign addr_nxt = ADDR_W'(sy) * WPR_L + ADDR_W'({1'b0, sx} / PPW_L);
  assign lane_nxt = LANE_W'({1'b0, sx} % PPW_L);

  // Active offsets move only at frame_start so a frame is never drawn with mixed offsets.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_x       <= '0;
      sh_y       <= '0;
      ac_x       <= '0;
      ac_y       <= '0;
      scroll_err <= 1'b0;
    end else begin
      scroll_err <= scroll_we && !wr_ok;
      if (scroll_we && wr_ok) begin
        sh_x <= scroll_x;
        sh_y <= scroll_y;
      end
      if (frame_start) begin
        ac_x <= (scroll_we && wr_ok) ? scroll_x : sh_x;
        ac_y <= (scroll_we && wr_ok) ? scroll_y : sh_y;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr  <= '0;
      lane_p0   <= '0;
      lane_p1   <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      pal_idx   <= '0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      pix_valid <= 1'b0;
    end else begin
      // stage 1: address generation
      rom_addr <= addr_nxt;
      lane_p0  <= lane_nxt;
      vld_p0   <= blank && in_img;
      // pixel ROM read cycle
      lane_p1  <= lane_p0;
      vld_p1   <= vld_p0;
      // stage 2: lane select
      pal_idx  <= lane_sel(rom_q, lane_p1);
      vld_p2   <= vld_p1;
      // palette ROM read cycle
      vld_p3   <= vld_p2;
      // stage 3: colour
      VGA_R     <= vld_p3 ? pal_rgb[23:20] : 4'd0;
      VGA_G     <= vld_p3 ? pal_rgb[15:12] : 4'd0;
      VGA_B     <= vld_p3 ? pal_rgb[7:4]   : 4'd0;
      pix_valid <= vld_p3;
    end
  end

endmodule

// File: tb/tb_bg_scroll_mapper.sv
// Bench for bg_scroll_mapper: synchronous ROM models plus a per-pixel reference model of
// scaling, scroll latching and wrap-around, checked every cycle at each pipeline tap.
module tb_bg_scroll_mapper;
  localparam int IMG_W = 320, IMG_H = 240, PPW = 8, PB = 8;
  localparam int WPR = IMG_W / PPW, ADDR_W = 14, SXW = 9, SYW = 8, WORD_W = 64;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [9:0]        DrawX, DrawY;
  logic              blank, frame_start, scroll_we;
  logic [SXW-1:0]    scroll_x;
  logic [SYW-1:0]    scroll_y;
  logic              scroll_err;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_q;
  logic [PB-1:0]     pal_idx;
  logic [23:0]       pal_rgb;
  logic [3:0]        VGA_R, VGA_G, VGA_B;
  logic              pix_valid;

  always #5 clock = ~clock;

  bg_scroll_mapper dut (
    .clock(clock), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .scroll_we(scroll_we), .scroll_x(scroll_x),
    .scroll_y(scroll_y), .scroll_err(scroll_err), .rom_addr(rom_addr), .rom_q(rom_q),
    .pal_idx(pal_idx), .pal_rgb(pal_rgb), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .pix_valid(pix_valid)
  );

  // Source image content: pixel n of the image (row-major, word-packed) has a known value.
  function automatic logic [7:0] pix_of(input int a, input int l);
    return 8'((a * PPW + l) * 37 + 11);
  endfunction

  function automatic logic [WORD_W-1:0] rom_word(input int a);
    logic [WORD_W-1:0] w;
    for (int l = 0; l < PPW; l++) w[WORD_W-1-l*PB -: PB] = pix_of(a, l);
    return w;
  endfunction

  function automatic logic [23:0] pal(input int i);
    return {8'(i * 7 + 3), 8'(i ^ 92), 8'(255 - i)};
  endfunction

  always @(posedge clock) begin
    rom_q   <= rom_word(int'(rom_addr));
    pal_rgb <= pal(int'(pal_idx));
  end

  typedef struct { bit known; bit vis; int addr; int pix; } ent_t;
  ent_t hist[$];
  int   total = 0, bad = 0;
  int   m_sh_x, m_sh_y, m_ac_x, m_ac_y;
  bit   m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ent_t z;
    z = '{known: 1'b0, vis: 1'b0, addr: 0, pix: 0};
    hist.delete();
    for (int i = 0; i < 4; i++) hist.push_back(z);
    m_sh_x = 0; m_sh_y = 0; m_ac_x = 0; m_ac_y = 0; m_err = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_rom_addr", rom_addr, 0);
    check("rst_pal_idx", pal_idx, 0);
    check("rst_vga_r", VGA_R, 0);
    check("rst_vga_g", VGA_G, 0);
    check("rst_vga_b", VGA_B, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_scroll_err", scroll_err, 0);
  endtask

  task automatic step();
    ent_t e, old;
    int hx, hy, sx, sy;
    bit ok;
    logic [23:0] c;
    @(posedge clock);
    hx = int'(DrawX) >> 1;
    hy = int'(DrawY) >> 1;
    sx = (hx + m_ac_x) % IMG_W;
    sy = (hy + m_ac_y) % IMG_H;
    e.known = (hx < IMG_W) && (hy < IMG_H);
    e.vis   = blank && e.known;
    e.addr  = sy * WPR + sx / PPW;
    e.pix   = int'(pix_of(e.addr, sx % PPW));
    hist.push_back(e);
    if (hist.size() > 5) void'(hist.pop_front());
    ok = (int'(scroll_x) < IMG_W) && (int'(scroll_y) < IMG_H);
    m_err = scroll_we && !ok;
    if (frame_start) begin
      m_ac_x = (scroll_we && ok) ? int'(scroll_x) : m_sh_x;
      m_ac_y = (scroll_we && ok) ? int'(scroll_y) : m_sh_y;
    end
    if (scroll_we && ok) begin
      m_sh_x = int'(scroll_x);
      m_sh_y = int'(scroll_y);
    end
    #1;
    if (e.known) check("rom_addr", rom_addr, e.addr);
    if (hist[2].known) check("pal_idx", pal_idx, hist[2].pix);
    old = hist[0];
    c = old.vis ? pal(old.pix) : 24'd0;
    check("vga_r", VGA_R, c[23:20]);
    check("vga_g", VGA_G, c[15:12]);
    check("vga_b", VGA_B, c[7:4]);
    check("pix_valid", pix_valid, old.vis);
    check("scroll_err", scroll_err, m_err);
  endtask

  task automatic drv(input int dx, input int dy, input bit bl, input bit fs, input bit we,
                     input int x, input int y);
    DrawX = 10'(dx); DrawY = 10'(dy); blank = bl; frame_start = fs; scroll_we = we;
    scroll_x = SXW'(x); scroll_y = SYW'(y);
    step();
  endtask

  task automatic rand_run(input int n);
    int dx, dy;
    for (int i = 0; i < n; i++) begin
      dx = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 639) : $urandom_range(0, 799);
      dy = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 479) : $urandom_range(0, 524);
      drv(dx, dy, $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 14) == 0, $urandom_range(0, 400), $urandom_range(0, 255));
    end
  endtask

  initial begin
    reset_n = 1'b1;
    DrawX = '0; DrawY = '0; blank = 1'b1; frame_start = 1'b0; scroll_we = 1'b0;
    scroll_x = '0; scroll_y = '0;
    #1 reset_n = 1'b0;
    #1 check_reset_outputs();
    @(posedge clock); @(posedge clock);
    #1 reset_n = 1'b1;
    model_reset();

    repeat (5) drv(0, 0, 1, 0, 0, 0, 0);
    repeat (5) drv(18, 0, 1, 0, 0, 0, 0);
    drv(20, 0, 1, 0, 1, 315, 0);
    drv(20, 0, 1, 1, 0, 0, 0);
    repeat (5) drv(20, 0, 1, 0, 0, 0, 0);
    drv(20, 4, 1, 0, 1, 315, 239);
    drv(20, 4, 1, 1, 0, 0, 0);
    repeat (5) drv(20, 4, 1, 0, 0, 0, 0);
    drv(40, 10, 1, 0, 1, 7, 0);
    repeat (3) drv(40, 10, 1, 0, 0, 0, 0);
    drv(40, 10, 1, 0, 1, 320, 0);
    repeat (2) drv(40, 10, 1, 0, 0, 0, 0);
    drv(40, 10, 1, 1, 0, 0, 0);
    repeat (4) drv(40, 10, 1, 0, 0, 0, 0);
    drv(40, 10, 1, 1, 1, 100, 50);
    repeat (4) drv(40, 10, 1, 0, 0, 0, 0);
    drv(60, 20, 1, 0, 0, 0, 0);
    repeat (5) drv(60, 20, 0, 0, 0, 0, 0);
    repeat (5) drv(640, 20, 1, 0, 0, 0, 0);
    drv(638, 478, 1, 0, 1, 319, 239);
    drv(638, 478, 1, 1, 0, 0, 0);
    repeat (5) drv(638, 478, 1, 0, 0, 0, 0);

    rand_run(600);

    #2 reset_n = 1'b0;
    #1 check_reset_outputs();
    @(posedge clock); @(posedge clock);
    #1 reset_n = 1'b1;
    model_reset();
    repeat (6) drv(100, 100, 1, 0, 0, 0, 0);
    rand_run(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bg_scroll_mapper.md
# bg_scroll_mapper

Pipelined, parameterised background pixel mapper for the VGA path. It converts the raster position into a word address in the background pixel ROM, extracts the palette index for the current pixel, and looks that index up in the palette ROM. It drives registered 4-bit VGA colour outputs. Unlike the previous mapper, it adds integer pixel scaling, tear-free horizontal/vertical scrolling with wrap-around, and a fixed, blank-aligned pipeline latency for synchronous-read ROMs.

## Interface
Parameters:
- IMG_W, 320: background width in source pixels; must be a multiple of PIX_PER_WORD.
- IMG_H, 240: background height in source pixels.
- SCALE_SHIFT, 1: screen-to-source shift. Source coordinate = Draw >> SCALE_SHIFT.
- PIX_BITS, 8: palette index width.
- PIX_PER_WORD, 8: pixels packed per ROM word. Pixel 0 (leftmost) occupies the MSBs.
- Derived localparams:
  - WORD_W = PIX_BITS*PIX_PER_WORD.
  - WPR = IMG_W/PIX_PER_WORD.
  - ADDR_W = $clog2(WPR*IMG_H).
  - SXW = $clog2(IMG_W).
  - SYW = $clog2(IMG_H).

Ports:
- clock, in, 1: pixel clock.
- reset_n, in, 1: asynchronous, active-low reset.
- DrawX, in, 10: current raster X.
- DrawY, in, 10: current raster Y.
- blank, in, 1: high = active video.
- frame_start, in, 1: one-cycle pulse at the start of vertical blanking.
- scroll_we, in, 1: write strobe for scroll_x/scroll_y.
- scroll_x, in, SXW: requested horizontal offset.
- scroll_y, in, SYW: requested vertical offset.
- scroll_err, out, 1: one-cycle pulse when a write is rejected.
- rom_addr, out, ADDR_W: registered address to the pixel ROM.
- rom_q, in, WORD_W: pixel ROM data, valid 1 cycle after rom_addr.
- pal_idx, out, PIX_BITS: registered index to the palette ROM.
- pal_rgb, in, 24: palette data {R8,G8,B8}, valid 1 cycle after pal_idx.
- VGA_R, out, 4: registered red output.
- VGA_G, out, 4: registered green output.
- VGA_B, out, 4: registered blue output.
- pix_valid, out, 1: blank delayed to align with the VGA outputs.

## Operation
- **Scroll registers:** shadow (sh_x, sh_y) and active (ac_x, ac_y).
  - On scroll_we: if scroll_x < IMG_W and scroll_y < IMG_H, load the shadow pair. Otherwise reject the whole write: shadow is unchanged and scroll_err pulses.
  - On frame_start: active ← shadow.
  - scroll_we and frame_start in the same cycle with a valid write: the active pair takes the incoming values directly, and the shadow also loads them.
  - The active pair never changes outside frame_start, so there is no mid-frame tearing.
- **Address generation (stage 1, edge k):**
  - hx = DrawX>>SCALE_SHIFT, hy = DrawY>>SCALE_SHIFT.
  - sx = hx+ac_x; if sx ≥ IMG_W then sx −= IMG_W. sy is computed the same way with ac_y and IMG_H. One conditional subtract suffices because all operands are < IMG_W/IMG_H.
  - hx ≥ IMG_W or hy ≥ IMG_H (outside the scaled image): treated as blank for this pixel.
  - rom_addr ← sy*WPR + sx/PIX_PER_WORD.
  - lane ← sx mod PIX_PER_WORD.
  - The blank pipeline bit is set to blank AND in-image.
- **Lane select (stage 2, edge k+2):** pal_idx ← rom_q[WORD_W−1−lane*PIX_BITS −: PIX_BITS], using lane delayed 1 cycle.
- **Colour (stage 3, edge k+4):**
  - If the delayed blank bit is 1: VGA_R/G/B ← pal_rgb[23:20]/[15:12]/[7:4].
  - Otherwise the outputs are 0.
  - pix_valid ← the delayed blank bit.
- The lane and blank bits are carried through a 4-deep shift alongside the data. There is no stall or backpressure; one pixel is accepted every cycle.

## Timing
- **Latency:** inputs sampled at edge k appear on VGA_R/G/B and pix_valid after edge k+4.
  - rom_addr updates after edge k.
  - pal_idx updates after edge k+2.
- **Reset (reset_n low, asynchronous):**
  - Outputs rom_addr, pal_idx, VGA_R/G/B, pix_valid and scroll_err go to 0 immediately.
  - Internal shadow/active scroll registers, lane and blank pipeline bits also clear to 0.
- **Reset released mid-frame:** outputs stay 0 for 4 cycles (blank pipeline cleared), then track the raster with scroll offset 0 until the first frame_start after a write.
- **Scroll latching:**
  - A write at edge j takes effect on pixels sampled after the next frame_start edge.
  - scroll_err is high for exactly the cycle after the rejected write.
- **Wrap-around:** the column after sx = IMG_W−1 is sx = 0, and the row after sy = IMG_H−1 is sy = 0. Neither needs extra cycles.

## Test plan
- **Reset:** reset_n = 0 with blank = 1 → all outputs 0 asynchronously. Release, then DrawX=0, DrawY=0 → rom_addr=0 after 1 edge, pix_valid=1 after 4 edges.
- **Lane extraction:** scroll 0, DrawX=18, DrawY=0 → rom_addr=1, pal_idx=rom_q[55:48]. pal_rgb=24'hA5C3F0 → VGA = A/C/F four cycles after the sample.
- **Horizontal wrap:** write scroll_x=315, pulse frame_start, DrawX=20, DrawY=0 → sx=5, rom_addr=0, pal_idx=rom_q[23:16].
- **Vertical wrap:** write scroll_y=239, pulse frame_start, DrawY=4 → rom_addr=40.
- **Deferred and rejected writes:**
  - Write scroll_x=7 mid-frame → rom_addr unchanged until frame_start.
  - Write scroll_x=320 → scroll_err pulses for 1 cycle and the shadow keeps 7.
  - scroll_we together with frame_start → new value active immediately.
- **Blanking alignment:** toggle blank 1→0 at sample k → VGA outputs 0 and pix_valid=0 after edge k+4, not earlier. DrawX=640 (hx=320) with blank=1 → outputs 0.
